mc_control_fsm: RTL and testbench

Multi-cycle control unit for the RV32I multi-cycle CPU. A Moore state machine sequences the shared ALU, unified instruction/data memory, register file and PC through the fetch, decode, execute, memory and writeback phases. It replaces the single-cycle combinational decoder. The memory port is handshaked, so fetch and data accesses may stall for any number of cycles.

---
 rtl/mc_ctrl_pkg.sv | 55 +++++
 rtl/mc_control_fsm_if.sv | 40 ++++
 rtl/mc_ctrl_outputs.sv | 85 ++++++++
 rtl/mc_control_fsm.sv | 72 +++++++
 tb/tb_mc_control_fsm.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: states, datapath
// select codes, opcodes and the control-word payload.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_EX_I, S_EX_ADDR, S_EX_BR, S_EX_JAL, S_EX_JALR,
    S_JALR_WB, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_PC_INC, S_ECALL, S_HALT
  } state_t;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned SEL_W    = 2;

  // alu_op codes
  localparam logic [SEL_W-1:0] ALU_ADD   = 2'd0;
  localparam logic [SEL_W-1:0] ALU_BR    = 2'd1;
  localparam logic [SEL_W-1:0] ALU_FUNCT = 2'd2;

  // alu_src_b codes
  localparam logic [SEL_W-1:0] SRCB_B    = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'd2;

  // wb_sel codes
  localparam logic [SEL_W-1:0] WB_ALUOUT = 2'd0;
  localparam logic [SEL_W-1:0] WB_MDR    = 2'd1;
  localparam logic [SEL_W-1:0] WB_ALU    = 2'd2;

  // RV32I major opcodes
  localparam logic [OPCODE_W-1:0] OP_ARITH     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD      = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE     = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH    = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL       = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR      = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_ECALL     = 7'b1110011;

  typedef struct packed {
    logic             pc_write;
    logic             pc_source;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic [SEL_W-1:0] wb_sel;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic             is_ecall;
    logic             retire;
    logic             halted;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath/memory bundle: status inputs to the controller and
// the control word it drives back.
interface mc_control_fsm_if;
  import mc_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                bcond;
  logic                mem_ready;
  logic                halt_req;

  logic                pc_write;
  logic                pc_source;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg_write;
  logic [SEL_W-1:0]    wb_sel;
  logic                alu_src_a;
  logic [SEL_W-1:0]    alu_src_b;
  logic [SEL_W-1:0]    alu_op;
  logic                is_ecall;
  logic                retire;
  logic                halted;

  modport master (
    input  opcode, bcond, mem_ready, halt_req,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_ecall,
           retire, halted
  );

  modport slave (
    output opcode, bcond, mem_ready, halt_req,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_ecall,
           retire, halted
  );

endinterface

// File: rtl/mc_ctrl_outputs.sv
// State -> control word decode. Moore except ir_write in IF (follows mem_ready)
// and pc_write/retire in EX_BR (follow bcond).
module mc_ctrl_outputs
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   bcond,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = mem_ready;
      end
      S_ID: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EX_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EX_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EX_ADDR, S_EX_JALR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EX_BR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_BR;
        ctrl.pc_source = 1'b1;
        ctrl.pc_write  = bcond;
        ctrl.retire    = bcond;
      end
      // Link register gets PC+4 from the live ALU; PC takes the stored target.
      S_EX_JAL, S_JALR_WB: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_ALU;
        ctrl.pc_source = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      // Writeback overlaps the PC+4 update so both land on the same edge.
      S_WB_ALU, S_WB_MEM: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = (state == S_WB_MEM) ? WB_MDR : WB_ALUOUT;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_PC_INC: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_ECALL: ctrl.is_ecall = 1'b1;
      S_HALT:  ctrl.halted   = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: state register and next-state sequencing
// through fetch, decode, execute, memory and writeback.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  mc_control_fsm_if.master  bus
);

  state_t state, state_next;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IF;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IF: if (bus.mem_ready) state_next = S_ID;
      S_ID: begin
        case (bus.opcode)
          OP_ARITH:          state_next = S_EX_R;
          OP_ARITH_IMM:      state_next = S_EX_I;
          OP_LOAD, OP_STORE: state_next = S_EX_ADDR;
          OP_BRANCH:         state_next = S_EX_BR;
          OP_JAL:            state_next = S_EX_JAL;
          OP_JALR:           state_next = S_EX_JALR;
          OP_ECALL:          state_next = S_ECALL;
          default:           state_next = S_PC_INC;
        endcase
      end
      S_EX_R, S_EX_I: state_next = S_WB_ALU;
      S_EX_ADDR:      state_next = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_EX_BR:        state_next = bus.bcond ? S_IF : S_PC_INC;
      S_EX_JAL:       state_next = S_IF;
      S_EX_JALR:      state_next = S_JALR_WB;
      S_JALR_WB:      state_next = S_IF;
      S_MEM_RD:       if (bus.mem_ready) state_next = S_WB_MEM;
      S_MEM_WR:       if (bus.mem_ready) state_next = S_PC_INC;
      S_WB_ALU, S_WB_MEM, S_PC_INC: state_next = S_IF;
      S_ECALL:        state_next = bus.halt_req ? S_HALT : S_PC_INC;
      S_HALT:         state_next = S_HALT;
      default:        state_next = S_IF;
    endcase
  end

  mc_ctrl_outputs u_outputs (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .bcond     (bus.bcond),
    .ctrl      (ctrl)
  );

  assign bus.pc_write  = ctrl.pc_write;
  assign bus.pc_source = ctrl.pc_source;
  assign bus.i_or_d    = ctrl.i_or_d;
  assign bus.mem_read  = ctrl.mem_read;
  assign bus.mem_write = ctrl.mem_write;
  assign bus.ir_write  = ctrl.ir_write;
  assign bus.reg_write = ctrl.reg_write;
  assign bus.wb_sel    = ctrl.wb_sel;
  assign bus.alu_src_a = ctrl.alu_src_a;
  assign bus.alu_src_b = ctrl.alu_src_b;
  assign bus.alu_op    = ctrl.alu_op;
  assign bus.is_ecall  = ctrl.is_ecall;
  assign bus.retire    = ctrl.retire;
  assign bus.halted    = ctrl.halted;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a cycle-by-cycle vector table from reset, then
// per-instruction cycle counts with injected memory wait states.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        bc;
    logic        rdy;
    logic        hq;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  logic [16:0] got;
  assign got = {bus.pc_write, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_write, bus.wb_sel, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.is_ecall, bus.retire, bus.halted};

  localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LW = 7'b0000011,
                         SW = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, ECL = 7'b1110011, UND = 7'b0000000;

  function automatic logic [16:0] mk(input logic pcw, pcs, iod, mr, mw, irw, rw,
                                     input logic [1:0] wb, input logic sa,
                                     input logic [1:0] sb, op,
                                     input logic ec, rt, h);
    return {pcw, pcs, iod, mr, mw, irw, rw, wb, sa, sb, op, ec, rt, h};
  endfunction

  task automatic check(input string name, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, a, e);
    end
  endtask

  task automatic add(input logic rst, input logic [6:0] op, input logic bc, rdy, hq,
                     input logic [16:0] exp);
    vec_t v;
    v.rst = rst; v.op = op; v.bc = bc; v.rdy = rdy; v.hq = hq; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Run one instruction from IF; return cycles up to and including retire.
  task automatic run_instr(input string name, input logic [6:0] op, input logic bc,
                           input int waits, input int exp_cycles);
    int left = waits;
    int cycles = 0;
    bit overlap = 0;
    for (int c = 1; c <= 40 && cycles == 0; c++) begin
      @(negedge clk);
      bus.opcode = op; bus.bcond = bc; bus.halt_req = 1'b0;
      if (bus.i_or_d && left > 0) begin
        bus.mem_ready = 1'b0;
        left--;
      end else begin
        bus.mem_ready = 1'b1;
      end
      #1;
      if (bus.mem_read && bus.mem_write) overlap = 1;
      if (bus.retire) cycles = c;
    end
    check({name, " cycles"}, cycles, exp_cycles);
    check({name, " rd_wr_overlap"}, int'(overlap), 0);
  endtask

  logic [16:0] x_if0, x_if1, x_id, x_exr, x_exi, x_exa, x_mrd, x_mwr, x_wba, x_wbm,
               x_brt, x_brn, x_jal, x_pci, x_ecl, x_hlt;

  initial begin
    //           pcw pcs iod mr mw irw rw wb sa sb op ec rt h
    x_if0 = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    x_if1 = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    x_id  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    x_exr = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0);
    x_exi = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0);
    x_exa = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    x_mrd = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    x_mwr = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    x_wba = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
    x_wbm = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0);
    x_brt = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
    x_brn = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    x_jal = mk(1, 1, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 1, 0);
    x_pci = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    x_ecl = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    x_hlt = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // reset held, then released
    add(0, UND, 0, 0, 0, x_if0);  add(1, UND, 0, 0, 0, x_if0);
    // add, zero wait
    add(1, ADD, 0, 1, 0, x_if1);  add(1, ADD, 0, 1, 0, x_id);
    add(1, ADD, 0, 1, 0, x_exr);  add(1, ADD, 0, 1, 0, x_wba);
    // lw with two wait cycles in MEM_RD
    add(1, LW, 0, 1, 0, x_if1);   add(1, LW, 0, 1, 0, x_id);
    add(1, LW, 0, 1, 0, x_exa);   add(1, LW, 0, 0, 0, x_mrd);
    add(1, LW, 0, 0, 0, x_mrd);   add(1, LW, 0, 1, 0, x_mrd);
    add(1, LW, 0, 1, 0, x_wbm);
    // beq taken, then not taken
    add(1, BR, 1, 1, 0, x_if1);   add(1, BR, 1, 1, 0, x_id);
    add(1, BR, 1, 1, 0, x_brt);
    add(1, BR, 0, 1, 0, x_if1);   add(1, BR, 0, 1, 0, x_id);
    add(1, BR, 0, 1, 0, x_brn);   add(1, BR, 0, 1, 0, x_pci);
    // jal, jalr
    add(1, JAL, 0, 1, 0, x_if1);  add(1, JAL, 0, 1, 0, x_id);
    add(1, JAL, 0, 1, 0, x_jal);
    add(1, JALR, 0, 1, 0, x_if1); add(1, JALR, 0, 1, 0, x_id);
    add(1, JALR, 0, 1, 0, x_exa); add(1, JALR, 0, 1, 0, x_jal);
    // addi with one fetch stall
    add(1, ADDI, 0, 0, 0, x_if0); add(1, ADDI, 0, 1, 0, x_if1);
    add(1, ADDI, 0, 1, 0, x_id);  add(1, ADDI, 0, 1, 0, x_exi);
    add(1, ADDI, 0, 1, 0, x_wba);
    // ecall without halt
    add(1, ECL, 0, 1, 0, x_if1);  add(1, ECL, 0, 1, 0, x_id);
    add(1, ECL, 0, 1, 0, x_ecl);  add(1, ECL, 0, 1, 0, x_pci);
    // undefined opcode executes as NOP
    add(1, UND, 0, 1, 0, x_if1);  add(1, UND, 0, 1, 0, x_id);
    add(1, UND, 0, 1, 0, x_pci);
    // store aborted by reset in MEM_WR, then completed
    add(1, SW, 0, 1, 0, x_if1);   add(1, SW, 0, 1, 0, x_id);
    add(1, SW, 0, 1, 0, x_exa);   add(1, SW, 0, 0, 0, x_mwr);
    add(0, SW, 0, 0, 0, x_if0);   add(1, SW, 0, 0, 0, x_if0);
    add(1, SW, 0, 1, 0, x_if1);   add(1, SW, 0, 1, 0, x_id);
    add(1, SW, 0, 1, 0, x_exa);   add(1, SW, 0, 1, 0, x_mwr);
    add(1, SW, 0, 1, 0, x_pci);
    // ecall with halt
    add(1, ECL, 0, 1, 1, x_if1);  add(1, ECL, 0, 1, 1, x_id);
    add(1, ECL, 0, 1, 1, x_ecl);  add(1, ECL, 1, 1, 1, x_hlt);
    add(1, ADD, 1, 1, 1, x_hlt);

    bus.opcode = UND; bus.bcond = 1'b0; bus.mem_ready = 1'b0; bus.halt_req = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset_n = vecs[i].rst;
      bus.opcode = vecs[i].op; bus.bcond = vecs[i].bc;
      bus.mem_ready = vecs[i].rdy; bus.halt_req = vecs[i].hq;
      #1;
      total++;
      if (got !== vecs[i].exp) begin
        bad++;
        $display("FAIL vec%0d: got=%05h expected=%05h", i, got, vecs[i].exp);
      end
    end

    // HALT is terminal: no retire or memory request while inputs toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'b1; bus.bcond = i[0]; bus.opcode = LW;
      #1;
      check("halt_hold", int'(got), int'(x_hlt));
    end

    // reset leaves HALT
    @(negedge clk);
    reset_n = 1'b0; bus.mem_ready = 1'b0;
    #1;
    check("reset_from_halt", int'(got), int'(x_if0));
    @(negedge clk);
    reset_n = 1'b1;

    run_instr("add",       ADD,  0, 0, 4);
    run_instr("addi",      ADDI, 0, 0, 4);
    run_instr("lw",        LW,   0, 0, 5);
    run_instr("lw_w3",     LW,   0, 3, 8);
    run_instr("sw_w2",     SW,   0, 2, 7);
    run_instr("beq_t",     BR,   1, 0, 3);
    run_instr("beq_nt",    BR,   0, 0, 4);
    run_instr("jal",       JAL,  0, 0, 3);
    run_instr("jalr",      JALR, 0, 0, 4);
    run_instr("ecall",     ECL,  0, 0, 4);
    run_instr("undef_nop", UND,  0, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
